// File: rtl/dff_response_checker_pkg.sv
// Shared state encoding and parameter defaults for the DFF response checker.
package dff_response_checker_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned NSamplesDefault = 16;
  localparam int unsigned CntWDefault     = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dff_response_checker.sv
// Checks a flip-flop under test for one-cycle q latency and complementary q_bar over a run.
module dff_response_checker
  import dff_response_checker_pkg::*;
#(
  parameter int unsigned N_SAMPLES = NSamplesDefault,
  parameter int unsigned CNT_W     = CntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             d_i,
  input  logic             q_i,
  input  logic             q_bar_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] first_err_idx_o
);

  localparam int unsigned IdxW = 8;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             d_prev_q, d_prev_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             cnt_clr, cnt_inc, mismatch, last_sample;
  logic [CNT_W-1:0] err_cnt;

  assign mismatch    = (q_i != d_prev_q) || (q_bar_i != ~q_i);
  assign last_sample = (idx_q == IdxW'(N_SAMPLES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    d_prev_d = d_prev_q;
    pass_d   = pass_q;
    first_d  = first_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StArm;
          cnt_clr = 1'b1;
          first_d = '1;
          pass_d  = 1'b0;
          idx_d   = '0;
        end
      end
      StArm: begin
        if (abort_i) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else begin
          d_prev_d = d_i;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        // Abort discards the comparison of this cycle so err_cnt stays frozen.
        if (abort_i) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else begin
          d_prev_d = d_i;
          idx_d    = idx_q + IdxW'(1);
          if (mismatch) begin
            cnt_inc = 1'b1;
            // A saturating counter never returns to zero, so zero means no earlier mismatch.
            if (err_cnt == '0) begin
              first_d = CNT_W'(idx_q);
            end
          end
          if (last_sample) begin
            state_d = StDone;
            pass_d  = (err_cnt == '0) && !mismatch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_d = (state_d == StArm) || (state_d == StCheck);
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      d_prev_q <= 1'b0;
      pass_q   <= 1'b0;
      first_q  <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      d_prev_q <= d_prev_d;
      pass_q   <= pass_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (err_cnt)
  );

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_cnt;
  assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Randomized directed runs against two checker instances (default and 4-bit/20-sample).
module tb_dff_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sstart = 1'b0;
  logic       abort = 1'b0;
  logic       d = 1'b0;
  logic       q = 1'b0;
  logic       qb = 1'b1;
  logic       busy, done, pass;
  logic [7:0] err, first;
  logic       sbusy, sdone, spass;
  logic [3:0] serr, sfirst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_response_checker dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .abort_i         (abort),
    .d_i             (d),
    .q_i             (q),
    .q_bar_i         (qb),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_cnt_o       (err),
    .first_err_idx_o (first)
  );

  dff_response_checker #(
    .N_SAMPLES (20),
    .CNT_W     (4)
  ) dut_sat (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (sstart),
    .abort_i         (abort),
    .d_i             (d),
    .q_i             (q),
    .q_bar_i         (qb),
    .busy_o          (sbusy),
    .done_o          (sdone),
    .pass_o          (spass),
    .err_cnt_o       (serr),
    .first_err_idx_o (sfirst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 random sparse faults, 1 ideal alternating, 2 q flipped at sample 5, 3 q_bar tied to q
  // abort_at: sample index to abort at, -1 none, -2 abort asserted together with start in IDLE
  task automatic run(input bit sat, input int mode, input int abort_at);
    bit         dseq[0:32];
    int         n, maxc, cnt, first_exp;
    bit         fq, fb;
    logic [7:0] ones;
    n         = sat ? 20 : 16;
    maxc      = sat ? 15 : 255;
    ones      = sat ? 8'h0F : 8'hFF;
    cnt       = 0;
    first_exp = -1;
    for (int k = 0; k <= n; k++) begin
      dseq[k] = (mode == 1) ? k[0] : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if (sat) sstart = 1'b1; else start = 1'b1;
    abort = (abort_at == -2);
    @(negedge clk);
    start  = 1'b0;
    sstart = 1'b0;
    abort  = 1'b0;
    d      = dseq[0];
    chk("arm_busy", sat ? sbusy : busy, 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("check_busy", sat ? sbusy : busy, 1);
      chk("check_no_done", sat ? sdone : done, 0);
      fq = 1'b0;
      fb = 1'b0;
      case (mode)
        0: begin fq = ($urandom_range(0, 7) == 0); fb = ($urandom_range(0, 7) == 0); end
        2: fq = (i == 5);
        3: fb = 1'b1;
        default: ;
      endcase
      d      = dseq[i+1];
      q      = dseq[i] ^ fq;
      qb     = fb ? q : ~q;
      sstart = sat && (i == 7);
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_err_frozen", err, cnt);
        chk("abort_first", first, (first_exp < 0) ? ones : 8'(first_exp));
        @(negedge clk);
        chk("abort_no_done_later", done, 0);
        return;
      end
      if (fq || fb) begin
        if (first_exp < 0) first_exp = i;
        cnt++;
      end
    end
    @(negedge clk);
    sstart = 1'b0;
    chk("done_pulse", sat ? sdone : done, 1);
    chk("done_busy", sat ? sbusy : busy, 0);
    chk("done_pass", sat ? spass : pass, (cnt == 0) ? 1 : 0);
    chk("done_err", sat ? serr : err, (cnt > maxc) ? maxc : cnt);
    chk("done_first", sat ? sfirst : first, (first_exp < 0) ? ones : (8'(first_exp) & ones));
    @(negedge clk);
    chk("idle_done_low", sat ? sdone : done, 0);
    chk("idle_pass_hold", sat ? spass : pass, (cnt == 0) ? 1 : 0);
    chk("idle_err_hold", sat ? serr : err, (cnt > maxc) ? maxc : cnt);
  endtask

  initial begin
    bit saw_done;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_first", first, 8'hFF);
    chk("rst_sat_first", sfirst, 4'hF);
    rst_n = 1'b1;

    run(1'b0, 1, -1);
    run(1'b0, 2, -1);
    run(1'b0, 3, -1);
    repeat (3) run(1'b0, 0, -1);
    run(1'b0, 0, 3);
    run(1'b0, 1, -1);
    run(1'b0, 0, -2);

    // Reset pulsed low mid-CHECK between clock edges.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      d  = 1'($urandom_range(0, 1));
      q  = ~d;
      qb = q;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_pass", pass, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_first", first, 8'hFF);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", saw_done, 0);
    chk("idle_after_rst", busy, 0);

    run(1'b1, 3, -1);
    run(1'b0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_response_checker.md
DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

Interface
REQ-001 Parameter: N_SAMPLES, default 16, number of clocked comparisons per run, legal range 1..255.
REQ-002 Parameter: CNT_W, default 8, width of the error counter and the index outputs.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock for all state.
REQ-004 rst_n input 1: asynchronous, active-low reset.
REQ-005 start input 1: a one-cycle pulse that begins a run; sampled only in IDLE.
REQ-006 abort input 1: ends a run immediately without asserting done.
REQ-007 d_in input 1: the stimulus value being driven into the flip-flop under test.
REQ-008 q_in input 1: q from the flip-flop under test.
REQ-009 q_bar_in input 1: q_bar from the flip-flop under test.
REQ-010 busy output 1: high while in ARM or CHECK.
REQ-011 done output 1: a one-cycle pulse when the run completes.
REQ-012 pass output 1: valid from done until the next start.
REQ-013 err_cnt output CNT_W: the number of mismatching samples in the current or last run.
REQ-014 first_err_idx output CNT_W: the sample index of the first mismatch; all-ones if there was none.

Function
REQ-015 The FSM SHALL have four states: IDLE, ARM, CHECK and DONE, binary-encoded.
REQ-016 IDLE->ARM on start=1; the block SHALL clear err_cnt, set first_err_idx to all-ones, clear pass and clear the sample index.
REQ-017 ARM SHALL last one cycle, capture d_in into d_prev, then go to CHECK; no comparison is made in ARM.
REQ-018 Each CHECK cycle SHALL compare q_in against d_prev and q_bar_in against ~q_in, then load d_prev with d_in, so the expected latency is one clock.
REQ-019 A mismatch is either comparison failing; it SHALL increment err_cnt by 1, saturating at 2^CNT_W-1.
REQ-020 On the first mismatch of a run, first_err_idx SHALL take the current sample index (0-based); later mismatches SHALL NOT change it.
REQ-021 The sample index SHALL increment once per CHECK cycle; after comparison N_SAMPLES-1 the FSM SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and pass=(err_cnt==0), counting the final comparison, then return to IDLE.
REQ-023 pass, err_cnt and first_err_idx SHALL hold their values in IDLE until the next accepted start.
REQ-024 start SHALL be ignored in ARM, CHECK and DONE, with no restart and no queuing.
REQ-025 abort=1 in ARM or CHECK SHALL force IDLE on the next edge with done=0 and pass=0, leaving err_cnt frozen.
REQ-026 abort SHALL take priority over a transition into DONE; abort in IDLE or DONE SHALL have no effect.
REQ-027 abort and start together in IDLE: start SHALL win, because abort has no effect in IDLE.
REQ-028 All outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, regardless of clk.
REQ-030 Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_idx=all-ones, d_prev=0, index=0.
REQ-031 Reset in the middle of a run SHALL discard that run; no done pulse SHALL follow the release of reset.

Structure
REQ-032 A shared package SHALL hold the state encoding constants and the defaults for N_SAMPLES and CNT_W.
REQ-033 The saturating counter SHALL be one sub-module, sat_counter, instantiated for err_cnt; it has increment and clear inputs.

Verification
REQ-034 Ideal DFF model, N_SAMPLES=16, alternating d_in -> done after 18 cycles from start, pass=1, err_cnt=0, first_err_idx=8'hFF.
REQ-035 q_in inverted only at sample 5 -> pass=0, err_cnt=1, first_err_idx=5.
REQ-036 q_bar_in tied to q_in for the whole run -> err_cnt=16, first_err_idx=0, pass=0.
REQ-037 abort at the 4th CHECK cycle -> IDLE next edge, done never pulses, pass=0; a new start is then accepted.
REQ-038 rst_n pulsed low mid-CHECK, asynchronously to clk -> all outputs at reset values within the same low phase, no later done.
REQ-039 Forced saturation with CNT_W=4 and N_SAMPLES=20, all mismatching -> err_cnt=15; a start pulse while busy is ignored.
